quadra_rx_buffer: RTL and testbench

// Receiving end of the quadra result stream. Captures y/y_dv from the quadra pipeline, which has
// no backpressure, into a FIFO and presents the results on a valid/ready master port.

---
 rtl/quadra_pkg.sv | 14 +
 rtl/quadra_rx_mem.sv | 26 ++
 rtl/quadra_rx_buffer.sv | 135 +++++++++++++
 tb/tb_quadra_rx_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/quadra_pkg.sv
// Shared types and constants for the quadra pipeline and its result buffer.
package quadra_pkg;

   localparam int QUADRA_LAT = 3;
   localparam int X_W        = 16;
   localparam int Y_W        = 16;

   typedef logic [X_W-1:0] x_t;
   typedef logic [Y_W-1:0] y_t;
   typedef logic           dv_t;
   typedef logic           ck_t;
   typedef logic           rs_t;

endpackage

// File: rtl/quadra_rx_mem.sv
// Result storage for the rx buffer: one synchronous write port, one asynchronous read port.
module quadra_rx_mem
   import quadra_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  ck_t                      clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  y_t                       wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output y_t                       rdata_o
);

   y_t mem_q [DEPTH];

   // Storage array write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/quadra_rx_buffer.sv
// Result FIFO behind the quadra pipeline with in-flight tracking and a credit output so the
// un-backpressured pipeline can never deliver into a full buffer.
module quadra_rx_buffer
   import quadra_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int PIPE_LAT = QUADRA_LAT
) (
   input  ck_t                    clk,
   input  rs_t                    rst_b,
   input  dv_t                    x_dv_mon,
   output logic                   x_ready,
   input  y_t                     y,
   input  dv_t                    y_dv,
   output y_t                     m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf,
   output logic                   unexp,
   input  logic                   err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = $clog2(((DEPTH > PIPE_LAT) ? DEPTH : PIPE_LAT) + 1);
   localparam int SW = ((LW > IW) ? LW : IW) + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [IW-1:0] in_flight_q, in_flight_d;
   logic          ovf_q, ovf_d;
   logic          unexp_q, unexp_d;
   logic          m_valid_q, m_valid_d;
   y_t            m_data_q, m_data_d;
   y_t            mem_rdata_s;
   logic          full_s, rd_en_s, wr_en_s;
   logic          ovf_evt_s, unexp_evt_s;
   logic [SW-1:0] credit_sum_s;

   quadra_rx_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_en_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (y),
      .raddr_i (rd_ptr_d),
      .rdata_o (mem_rdata_s)
   );

   // Next-state for pointers, occupancy, in-flight count, sticky flags and output stage.
   always_comb begin
      full_s      = (level_q == LW'(DEPTH));
      rd_en_s     = m_valid_q & m_ready;
      wr_en_s     = y_dv & (~full_s | rd_en_s);
      ovf_evt_s   = y_dv & full_s & ~rd_en_s;
      unexp_evt_s = y_dv & (in_flight_q == IW'(0));

      wr_ptr_d    = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d    = rd_en_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      level_d     = level_q + LW'(wr_en_s) - LW'(rd_en_s);
      // Saturate at zero: a result with nothing in flight is flagged, not counted.
      in_flight_d = in_flight_q + IW'(x_dv_mon) - IW'(y_dv & ~unexp_evt_s);

      ovf_d       = ovf_evt_s | (ovf_q & ~err_clr);
      unexp_d     = unexp_evt_s | (unexp_q & ~err_clr);

      m_valid_d   = (level_d != LW'(0));
      if (m_valid_d) begin
         // The new head is the word being written this cycle when it lands at the read slot.
         if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            m_data_d = y;
         end else begin
            m_data_d = mem_rdata_s;
         end
      end else begin
         m_data_d = m_data_q;
      end
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Occupancy and in-flight counters.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         level_q     <= LW'(0);
         in_flight_q <= IW'(0);
      end else begin
         level_q     <= level_d;
         in_flight_q <= in_flight_d;
      end
   end

   // Sticky error flags.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ovf_q   <= 1'b0;
         unexp_q <= 1'b0;
      end else begin
         ovf_q   <= ovf_d;
         unexp_q <= unexp_d;
      end
   end

   // Registered first-word-fall-through output stage.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         m_valid_q <= 1'b0;
         m_data_q  <= y_t'(0);
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign credit_sum_s = SW'(level_q) + SW'(in_flight_q);
   assign x_ready      = (credit_sum_s < SW'(DEPTH));
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign level        = level_q;
   assign ovf          = ovf_q;
   assign unexp        = unexp_q;

endmodule

// File: tb/tb_quadra_rx_buffer.sv
// Directed bench for quadra_rx_buffer with a 3-cycle pipeline model feeding y/y_dv.
module tb_quadra_rx_buffer;
   import quadra_pkg::*;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       x_dv_mon;
   logic       x_ready;
   y_t         y;
   logic       y_dv;
   y_t         m_data;
   logic       m_valid;
   logic       m_ready;
   logic [3:0] level;
   logic       ovf;
   logic       unexp;
   logic       err_clr;

   int n_vec = 0;
   int n_err = 0;

   logic pv [3];
   y_t   py [3];
   logic pipe_en;
   y_t   x_val;
   int   n_acc;

   quadra_rx_buffer #(.DEPTH(8), .PIPE_LAT(3)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .x_dv_mon (x_dv_mon),
      .x_ready  (x_ready),
      .y        (y),
      .y_dv     (y_dv),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .level    (level),
      .ovf      (ovf),
      .unexp    (unexp),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle; the pipeline model shifts x in and presents its oldest stage on y/y_dv.
   task automatic tick();
      @(posedge clk);
      #1;
      if (pipe_en) begin
         pv[2] = pv[1]; py[2] = py[1];
         pv[1] = pv[0]; py[1] = py[0];
         pv[0] = x_dv_mon; py[0] = x_val;
         y_dv = pv[2];
         y    = py[2];
      end
   endtask

   task automatic fill(input int base);
      m_ready = 1'b0;
      pipe_en = 1'b1;
      n_acc   = 0;
      for (int i = 0; i < 12; i++) begin
         x_dv_mon = x_ready;
         x_val    = y_t'(base + n_acc);
         if (x_ready) n_acc++;
         tick();
      end
      x_dv_mon = 1'b0;
      repeat (4) tick();
      pipe_en = 1'b0;
      y_dv    = 1'b0;
   endtask

   initial begin
      rst_b = 1'b0; x_dv_mon = 1'b0; y = '0; y_dv = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
      x_val = '0; pipe_en = 1'b0;
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; py[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data",  32'(m_data),  32'd0);
      chk("rst_x_ready", 32'(x_ready), 32'd1);
      chk("rst_level",   32'(level),   32'd0);
      chk("rst_ovf",     32'(ovf),     32'd0);
      chk("rst_unexp",   32'(unexp),   32'd0);
      rst_b = 1'b1;

      // single sample through the pipeline
      pipe_en = 1'b1; x_dv_mon = 1'b1; x_val = 16'd25;
      tick();
      x_dv_mon = 1'b0;
      chk("t1_inflight1", 32'(dut.in_flight_q), 32'd1);
      tick(); tick(); tick();
      chk("t1_m_valid", 32'(m_valid), 32'd1);
      chk("t1_m_data",  32'(m_data),  32'd25);
      chk("t1_level1",  32'(level),   32'd1);
      chk("t1_inflight0", 32'(dut.in_flight_q), 32'd0);
      m_ready = 1'b1;
      tick();
      chk("t1_level0",  32'(level),   32'd0);
      chk("t1_empty",   32'(m_valid), 32'd0);
      chk("t1_hold",    32'(m_data),  32'd25);
      m_ready = 1'b0;

      // credit fill
      fill(100);
      chk("t2_accepted", 32'(n_acc),   32'd8);
      chk("t2_x_ready",  32'(x_ready), 32'd0);
      chk("t2_level",    32'(level),   32'd8);
      chk("t2_ovf",      32'(ovf),     32'd0);
      chk("t2_unexp",    32'(unexp),   32'd0);
      chk("t2_head",     32'(m_data),  32'd100);

      // read and write together at full
      y = 16'd200; y_dv = 1'b1; m_ready = 1'b1;
      tick();
      y_dv = 1'b0;
      chk("t3_level", 32'(level),  32'd8);
      chk("t3_ovf",   32'(ovf),    32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("t3_valid", 32'(m_valid), 32'd1);
         chk("t3_order", 32'(m_data), (i < 7) ? 32'(101 + i) : 32'd200);
         tick();
      end
      chk("t3_drained", 32'(level),   32'd0);
      chk("t3_empty",   32'(m_valid), 32'd0);
      m_ready = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t3_clr_unexp", 32'(unexp), 32'd0);

      // forced overflow
      fill(300);
      chk("t4_accepted", 32'(n_acc), 32'd8);
      y = 16'd99; y_dv = 1'b1;
      tick();
      y_dv = 1'b0;
      chk("t4_ovf",   32'(ovf),    32'd1);
      chk("t4_level", 32'(level),  32'd8);
      chk("t4_head",  32'(m_data), 32'd300);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t4_ovf_clr", 32'(ovf), 32'd0);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t4_order", 32'(m_data), 32'(300 + i));
         tick();
      end
      chk("t4_drained", 32'(level), 32'd0);
      m_ready = 1'b0;

      // unexpected result, then clear colliding with a new event
      y = 16'd55; y_dv = 1'b1;
      tick();
      chk("t5_unexp",    32'(unexp), 32'd1);
      chk("t5_inflight", 32'(dut.in_flight_q), 32'd0);
      chk("t5_level",    32'(level), 32'd1);
      chk("t5_data",     32'(m_data), 32'd55);
      y = 16'd56; err_clr = 1'b1;
      tick();
      chk("t5_set_wins", 32'(unexp), 32'd1);
      chk("t5_level2",   32'(level), 32'd2);
      y_dv = 1'b0;
      tick();
      err_clr = 1'b0;
      chk("t5_cleared", 32'(unexp), 32'd0);
      m_ready = 1'b1;
      chk("t5_first", 32'(m_data), 32'd55);
      tick();
      chk("t5_second", 32'(m_data), 32'd56);
      tick();
      chk("t5_drained", 32'(level), 32'd0);
      m_ready = 1'b0;

      // mid-stream reset
      pipe_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         x_dv_mon = 1'b1; x_val = y_t'(400 + i);
         tick();
      end
      x_dv_mon = 1'b0;
      tick();
      chk("t6_level3",    32'(level), 32'd3);
      chk("t6_inflight2", 32'(dut.in_flight_q), 32'd2);
      #2 rst_b = 1'b0;
      #1;
      chk("t6_rst_valid",  32'(m_valid), 32'd0);
      chk("t6_rst_data",   32'(m_data),  32'd0);
      chk("t6_rst_level",  32'(level),   32'd0);
      chk("t6_rst_xready", 32'(x_ready), 32'd1);
      chk("t6_rst_unexp",  32'(unexp),   32'd0);
      chk("t6_rst_inflight", 32'(dut.in_flight_q), 32'd0);
      rst_b = 1'b1;
      tick();
      tick();
      chk("t6_late_level", 32'(level),  32'd2);
      chk("t6_late_unexp", 32'(unexp),  32'd1);
      chk("t6_late_data",  32'(m_data), 32'd403);
      chk("t6_late_inflight", 32'(dut.in_flight_q), 32'd0);
      pipe_en = 1'b0; y_dv = 1'b0; m_ready = 1'b1;
      tick();
      chk("t6_late_data2", 32'(m_data), 32'd404);
      tick();
      chk("t6_drained", 32'(level), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
